// File: rtl/dut_cmd_master.sv
// Command master for the dut register/queue interface: buffers write/read commands in an
// in-order queue, issues them over the enable/ready method ports and returns read responses.
module dut_cmd_master #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 3,
   parameter int STALL_MAX = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_data,
   output logic [ADDR_W-1:0] write_address,
   output logic              write_data,
   output logic              write_en,
   input  logic              write_rdy,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic              read_data,
   input  logic              read_rdy,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [7:0]        wr_count,
   output logic [7:0]        rd_count,
   output logic              stall_err
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int STALL_W = $clog2(STALL_MAX) + 1;

   logic              op_q   [DEPTH];
   logic              op_d   [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic              data_q [DEPTH];
   logic              data_d [DEPTH];

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
   logic [7:0]         wr_count_q, wr_count_d;
   logic [7:0]         rd_count_q, rd_count_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic               stall_err_q, stall_err_d;

   logic              head_valid;
   logic              head_op;
   logic [ADDR_W-1:0] head_addr;
   logic              head_data;
   logic              push;
   logic              pop;

   // Everything toward the dut is decoded from registered queue state only.
   assign head_valid = (count_q != '0);
   assign head_op    = op_q[rd_ptr_q];
   assign head_addr  = addr_q[rd_ptr_q];
   assign head_data  = data_q[rd_ptr_q];

   assign cmd_ready = (count_q != CNT_W'(DEPTH));
   assign write_en  = head_valid & ~head_op & write_rdy;
   assign read_en   = head_valid & head_op & read_rdy & (~rsp_valid_q | rsp_ready);
   assign push      = cmd_valid & cmd_ready;
   assign pop       = write_en | read_en;

   assign write_address = (head_valid & ~head_op) ? head_addr : '0;
   assign write_data    = head_valid & ~head_op & head_data;
   assign read_address  = (head_valid & head_op) ? head_addr : '0;

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = rsp_addr_q;
   assign wr_count  = wr_count_q;
   assign rd_count  = rd_count_q;
   assign stall_err = stall_err_q;

   always_comb begin
      op_d     = op_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         op_d[wr_ptr_q]   = cmd_op;
         addr_d[wr_ptr_q] = cmd_addr;
         data_d[wr_ptr_q] = cmd_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // A read firing in the same edge the old response is consumed reloads the holding slot.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_addr_d  = rsp_addr_q;
      if (read_en) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = read_data;
         rsp_addr_d  = head_addr;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_comb begin
      wr_count_d = wr_count_q + (write_en ? 8'd1 : 8'd0);
      rd_count_d = rd_count_q + (read_en ? 8'd1 : 8'd0);
      if (!head_valid || pop) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q == STALL_W'(STALL_MAX)) begin
         stall_cnt_d = stall_cnt_q;
      end else begin
         stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
      stall_err_d = stall_err_q | (stall_cnt_d == STALL_W'(STALL_MAX));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= 1'b0;
            addr_q[i] <= '0;
            data_q[i] <= 1'b0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         rsp_addr_q  <= '0;
         wr_count_q  <= '0;
         rd_count_q  <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         op_q        <= op_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_addr_q  <= rsp_addr_d;
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

endmodule

// File: tb/tb_dut_cmd_master.sv
// Bench for dut_cmd_master: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a queue-level model of the command master.
module tb_dut_cmd_master;

   localparam int DEPTH     = 4;
   localparam int ADDR_W    = 3;
   localparam int STALL_MAX = 8;

   logic              CLK = 1'b0;
   logic              RST;
   logic              cmd_valid, cmd_ready, cmd_op, cmd_data;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] write_address, read_address, rsp_addr;
   logic              write_data, write_en, write_rdy;
   logic              read_en, read_data, read_rdy;
   logic              rsp_valid, rsp_ready, rsp_data;
   logic [7:0]        wr_count, rd_count;
   logic              stall_err;

   always #5 CLK = ~CLK;

   dut_cmd_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STALL_MAX(STALL_MAX)) u_dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .write_address(write_address), .write_data(write_data),
      .write_en(write_en), .write_rdy(write_rdy),
      .read_address(read_address), .read_en(read_en),
      .read_data(read_data), .read_rdy(read_rdy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_addr(rsp_addr),
      .wr_count(wr_count), .rd_count(rd_count), .stall_err(stall_err)
   );

   typedef struct packed {
      logic              op;
      logic [ADDR_W-1:0] addr;
      logic              data;
   } cmd_t;

   // Reference model: pending commands, held response, counters, watchdog.
   cmd_t              mq[$];
   logic              m_rsp_v, m_rsp_d;
   logic [ADDR_W-1:0] m_rsp_a;
   int                m_wr, m_rd, m_stall;
   logic              m_err;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_rsp_v = 1'b0; m_rsp_d = 1'b0; m_rsp_a = '0;
      m_wr = 0; m_rd = 0; m_stall = 0; m_err = 1'b0;
   endtask

   function automatic logic f_we();
      return (mq.size() > 0) && (mq[0].op == 1'b0) && write_rdy;
   endfunction

   function automatic logic f_re();
      return (mq.size() > 0) && (mq[0].op == 1'b1) && read_rdy && (!m_rsp_v || rsp_ready);
   endfunction

   task automatic compare();
      logic              hv;
      cmd_t              h;
      hv = (mq.size() > 0);
      h  = hv ? mq[0] : '0;
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("write_en", write_en, f_we());
      chk("read_en", read_en, f_re());
      chk("write_address", write_address, (hv && !h.op) ? h.addr : '0);
      chk("write_data", write_data, hv && !h.op && h.data);
      chk("read_address", read_address, (hv && h.op) ? h.addr : '0);
      chk("rsp_valid", rsp_valid, m_rsp_v);
      chk("rsp_data", rsp_data, m_rsp_d);
      chk("rsp_addr", rsp_addr, m_rsp_a);
      chk("wr_count", wr_count, m_wr);
      chk("rd_count", rd_count, m_rd);
      chk("stall_err", stall_err, m_err);
   endtask

   task automatic model_update();
      int   sz;
      logic we, re;
      cmd_t c;
      sz = mq.size();
      we = f_we();
      re = f_re();
      if (re) begin
         m_rsp_v = 1'b1; m_rsp_d = read_data; m_rsp_a = mq[0].addr;
      end else if (rsp_ready) begin
         m_rsp_v = 1'b0;
      end
      if (we) m_wr = (m_wr + 1) % 256;
      if (re) m_rd = (m_rd + 1) % 256;
      if (we || re) void'(mq.pop_front());
      if (cmd_valid && sz < DEPTH) begin
         c.op = cmd_op; c.addr = cmd_addr; c.data = cmd_data;
         mq.push_back(c);
      end
      if (sz == 0 || we || re) m_stall = 0;
      else if (m_stall < STALL_MAX) m_stall++;
      if (m_stall == STALL_MAX) m_err = 1'b1;
   endtask

   // One clock: check outputs mid-cycle, advance the model, return just after the edge.
   task automatic cycle();
      @(negedge CLK);
      compare();
      model_update();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_idle();
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = 1'b0;
      write_rdy = 1'b0; read_rdy = 1'b0; read_data = 1'b0; rsp_ready = 1'b0;
   endtask

   task automatic push_cmd(input logic op, input int addr, input logic data);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = ADDR_W'(addr); cmd_data = data;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      model_reset();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      drive_idle();
      apply_reset();
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_write_en", write_en, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_wr_count", wr_count, 0);
      chk("reset_stall_err", stall_err, 0);

      // Single write
      write_rdy = 1'b1;
      push_cmd(1'b0, 4, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      #1;
      chk("single_write_en", write_en, 1);
      chk("single_write_addr", write_address, 4);
      chk("single_write_data", write_data, 1);
      cycle();
      chk("single_wr_count", wr_count, 1);

      // Fill and backpressure
      write_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_cmd(1'b0, i, i[0]);
         cycle();
         if (i == 3) chk("fill_full", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      write_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_write_en", write_en, 1);
         chk("drain_addr", write_address, i);
         cycle();
         if (i == 0) chk("ready_after_pop", cmd_ready, 1);
      end
      chk("drain_wr_count", wr_count, 5);

      // Read round trip
      write_rdy = 1'b0; read_rdy = 1'b1; read_data = 1'b1; rsp_ready = 1'b0;
      push_cmd(1'b1, 3, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      #1;
      chk("rt_read_en", read_en, 1);
      chk("rt_read_addr", read_address, 3);
      cycle();
      chk("rt_rsp_valid", rsp_valid, 1);
      chk("rt_rsp_data", rsp_data, 1);
      chk("rt_rsp_addr", rsp_addr, 3);
      chk("rt_rd_count", rd_count, 1);
      rsp_ready = 1'b1;
      cycle();

      // Response backpressure
      rsp_ready = 1'b0; read_rdy = 1'b0; read_data = 1'b0;
      push_cmd(1'b1, 5, 1'b0);
      cycle();
      push_cmd(1'b1, 6, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      read_rdy = 1'b1;
      #1;
      chk("bp_first_read_en", read_en, 1);
      cycle();
      chk("bp_rsp_addr", rsp_addr, 5);
      repeat (2) begin
         chk("bp_withheld", read_en, 0);
         cycle();
      end
      chk("bp_rsp_held", rsp_addr, 5);
      read_data = 1'b1; rsp_ready = 1'b1;
      #1;
      chk("bp_second_read_en", read_en, 1);
      cycle();
      chk("bp_rsp_valid_kept", rsp_valid, 1);
      chk("bp_rsp_addr2", rsp_addr, 6);
      chk("bp_rsp_data2", rsp_data, 1);
      cycle();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         cmd_valid = ($urandom_range(0, 99) < 60);
         cmd_op    = 1'($urandom_range(0, 1));
         cmd_addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
         cmd_data  = 1'($urandom_range(0, 1));
         write_rdy = ($urandom_range(0, 99) < 75);
         read_rdy  = ($urandom_range(0, 99) < 75);
         read_data = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 99) < 60);
         cycle();
      end

      // Watchdog
      drive_idle();
      apply_reset();
      push_cmd(1'b0, 1, 1'b1);
      cycle();
      cmd_valid = 1'b0;
      repeat (7) cycle();
      chk("wd_not_yet", stall_err, 0);
      cycle();
      chk("wd_set", stall_err, 1);
      write_rdy = 1'b1;
      repeat (3) cycle();
      chk("wd_sticky", stall_err, 1);
      chk("wd_drained", cmd_ready, 1);

      // Reset mid-operation
      drive_idle();
      read_rdy = 1'b1; read_data = 1'b1;
      push_cmd(1'b1, 2, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      cycle();
      read_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_cmd(1'b0, i + 5, 1'b1);
         cycle();
      end
      cmd_valid = 1'b0;
      chk("mid_rsp_valid_before", rsp_valid, 1);
      write_rdy = 1'b1;
      #1;
      chk("mid_write_en_before", write_en, 1);
      RST = 1'b1;
      #1;
      chk("mid_write_en_drop", write_en, 0);
      chk("mid_read_en_drop", read_en, 0);
      chk("mid_rsp_valid_drop", rsp_valid, 0);
      model_reset();
      @(posedge CLK);
      #3 RST = 1'b0;
      @(posedge CLK);
      #1;
      read_rdy = 1'b1; rsp_ready = 1'b1;
      repeat (20) cycle();
      chk("post_reset_wr_count", wr_count, 0);
      chk("post_reset_rd_count", rd_count, 0);
      chk("post_reset_stall_err", stall_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
